// File: rtl/cordic_nco_drv.sv
// NCO front end for cordic_top: emits a registered stream of rotation-mode
// requests whose z word is a phase ramp, with fixed or continuous burst length.
`timescale 1ns/1ps

module cordic_nco_drv #(
  parameter int IN_WIDTH    = 16,
  parameter int PHASE_WIDTH = 32,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [LEN_WIDTH-1:0]   len_in,
  input  logic [IN_WIDTH-1:0]    amp_in,
  input  logic [IN_WIDTH-1:0]    phase_off_in,
  input  logic [PHASE_WIDTH-1:0] freq_in,
  input  logic                   freq_ld,
  output logic                   busy,
  output logic                   done,
  output logic                   en_out,
  output logic [1:0]             mode_out,
  output logic [IN_WIDTH-1:0]    x_out,
  output logic [IN_WIDTH-1:0]    y_out,
  output logic [IN_WIDTH-1:0]    z_out
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [1:0] MODE_ROTATE = 2'd2;

  state_e                 state_q;
  logic [PHASE_WIDTH-1:0] acc_q;
  logic [PHASE_WIDTH-1:0] freq_act_q;
  logic [LEN_WIDTH-1:0]   cnt_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [IN_WIDTH-1:0]    amp_q;
  logic [IN_WIDTH-1:0]    off_q;

  logic [IN_WIDTH-1:0]    z_d;
  logic                   end_d;

  // Phase word is the top of the accumulator plus the latched offset, wrapping.
  assign z_d   = acc_q[PHASE_WIDTH-1 -: IN_WIDTH] + off_q;
  assign end_d = stop || ((len_q != '0) && (cnt_q == len_q));

  // NOTE: every register here is sequential state, so only non-blocking
  // assignments are used; the reset is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      freq_act_q <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      amp_q      <= '0;
      off_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      en_out     <= 1'b0;
      mode_out   <= '0;
      x_out      <= '0;
      y_out      <= '0;
      z_out      <= '0;
    end else begin
      if (freq_ld) freq_act_q <= freq_in;
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            acc_q    <= freq_act_q;
            cnt_q    <= LEN_WIDTH'(1);
            amp_q    <= amp_in;
            off_q    <= phase_off_in;
            len_q    <= len_in;
            busy     <= 1'b1;
            en_out   <= 1'b1;
            mode_out <= MODE_ROTATE;
            x_out    <= amp_in;
            y_out    <= '0;
            z_out    <= phase_off_in;
          end
        end
        RUN: begin
          if (end_d) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            en_out   <= 1'b0;
            mode_out <= '0;
            x_out    <= '0;
            y_out    <= '0;
            z_out    <= '0;
          end else begin
            acc_q    <= acc_q + freq_act_q;
            // Saturate so a continuous burst never wraps into a false length match.
            if (cnt_q != '1) cnt_q <= cnt_q + LEN_WIDTH'(1);
            en_out   <= 1'b1;
            mode_out <= MODE_ROTATE;
            x_out    <= amp_q;
            y_out    <= '0;
            z_out    <= z_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_nco_drv.sv
// Self-checking bench for cordic_nco_drv: directed test-plan scenarios plus
// randomized bursts against a sample-level phase model.
`timescale 1ns/1ps

module tb_cordic_nco_drv;

  localparam int IW = 16;
  localparam int PW = 32;
  localparam int LW = 16;
  localparam int VW = 5 + 3 * IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          freq_ld = 1'b0;
  logic [LW-1:0] len_in = '0;
  logic [IW-1:0] amp_in = '0;
  logic [IW-1:0] phase_off_in = '0;
  logic [PW-1:0] freq_in = '0;
  logic          busy, done, en_out;
  logic [1:0]    mode_out;
  logic [IW-1:0] x_out, y_out, z_out;

  cordic_nco_drv #(.IN_WIDTH(IW), .PHASE_WIDTH(PW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .len_in(len_in),
    .amp_in(amp_in), .phase_off_in(phase_off_in), .freq_in(freq_in),
    .freq_ld(freq_ld), .busy(busy), .done(done), .en_out(en_out),
    .mode_out(mode_out), .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a burst is a count of emitted samples plus the total
  // phase advanced so far; sample k carries top(total) + offset.
  bit            m_run;
  logic [PW-1:0] m_inc;
  logic [PW-1:0] m_phase;
  logic [IW-1:0] m_amp, m_off;
  int            m_len, m_k;
  logic [IW-1:0] obs_z;
  logic          obs_en, obs_done;

  task automatic model_reset();
    m_run = 0; m_inc = '0; m_phase = '0; m_amp = '0; m_off = '0;
    m_len = 0; m_k = 0;
  endtask

  // One clock: drive controls, predict the sample, compare the whole output word.
  task automatic drive_cycle(input bit st, input bit sp, input bit fl,
                             input logic [PW-1:0] fin, input string tag);
    logic [VW-1:0] exp_v, got_v;
    logic [IW-1:0] zz;
    start = st; stop = sp; freq_ld = fl; freq_in = fin;
    exp_v = '0;
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_amp = amp_in; m_off = phase_off_in; m_len = int'(len_in);
        exp_v = {1'b1, 1'b0, 1'b1, 2'd2, amp_in, 16'h0, phase_off_in};
        m_phase = m_inc; m_k = 1;
      end
    end else if (sp || (m_len != 0 && m_k >= m_len)) begin
      m_run = 0;
      exp_v = {1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0};
    end else begin
      zz = m_phase[PW-1 -: IW] + m_off;
      exp_v = {1'b1, 1'b0, 1'b1, 2'd2, m_amp, 16'h0, zz};
      m_phase = m_phase + m_inc;
      m_k++;
    end
    if (fl) m_inc = fin;
    @(posedge clk); #1;
    got_v = {busy, done, en_out, mode_out, x_out, y_out, z_out};
    obs_z = z_out; obs_en = en_out; obs_done = done;
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got busy/done/en/mode/x/y/z=%h expected %h", tag, got_v, exp_v);
    end
    start = 0; stop = 0; freq_ld = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, en_out, mode_out, x_out, y_out, z_out} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected 0", {busy, done, en_out, mode_out, x_out, y_out, z_out});
    end
    rst_n = 1'b0;
    model_reset();
    drive_cycle(0, 0, 0, '0, "idle_after_reset");
  endtask

  task automatic test_quadrature();
    logic [IW-1:0] zexp [8] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000,
                                16'h0000, 16'h4000, 16'h8000, 16'hC000};
    drive_cycle(0, 0, 1, 32'h4000_0000, "quad_load");
    len_in = 16'd8; amp_in = 16'h7FFF; phase_off_in = '0;
    for (int k = 0; k < 8; k++) begin
      drive_cycle(k == 0, 0, 0, '0, "quad_sample");
      n_checks++;
      if (obs_z !== zexp[k] || obs_en !== 1'b1) begin
        n_errors++;
        $display("FAIL quad_z[%0d]: got z=%h en=%b expected z=%h en=1", k, obs_z, obs_en, zexp[k]);
      end
    end
    drive_cycle(0, 0, 0, '0, "quad_done");
    n_checks++;
    if (obs_done !== 1'b1 || obs_en !== 1'b0) begin
      n_errors++;
      $display("FAIL quad_done: got done=%b en=%b expected done=1 en=0", obs_done, obs_en);
    end
    drive_cycle(0, 0, 0, '0, "quad_after");
    n_checks++;
    if (obs_done !== 1'b0) begin
      n_errors++;
      $display("FAIL quad_done_width: got done=%b expected 0", obs_done);
    end
  endtask

  task automatic test_ignore_start();
    int samples = 0;
    drive_cycle(0, 0, 1, '0, "ign_load");
    len_in = 16'd3; amp_in = 16'($urandom); phase_off_in = 16'h2000;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(k < 3, 0, 0, '0, "ign_cycle");
      if (obs_en === 1'b1) begin
        samples++;
        n_checks++;
        if (obs_z !== 16'h2000) begin
          n_errors++;
          $display("FAIL ign_z: got %h expected 2000", obs_z);
        end
      end
    end
    n_checks++;
    if (samples != 3) begin
      n_errors++;
      $display("FAIL ign_count: got %0d samples expected 3", samples);
    end
  endtask

  task automatic test_wrap();
    logic [IW-1:0] zexp [3] = '{16'h0000, 16'hFFFF, 16'hFFFF};
    drive_cycle(0, 0, 1, 32'hFFFF_FFFF, "wrap_load");
    len_in = 16'd3; phase_off_in = '0;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(k == 0, 0, 0, '0, "wrap_sample");
      n_checks++;
      if (obs_z !== zexp[k]) begin
        n_errors++;
        $display("FAIL wrap_z[%0d]: got %h expected %h", k, obs_z, zexp[k]);
      end
    end
    drive_cycle(0, 0, 0, '0, "wrap_done");
    drive_cycle(0, 0, 0, '0, "wrap_idle");
  endtask

  task automatic test_continuous();
    logic [IW-1:0] zexp [8] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000,
                                16'h4000, 16'h6000, 16'h8000, 16'hA000};
    drive_cycle(0, 0, 1, 32'h1000_0000, "cont_load");
    len_in = '0; phase_off_in = '0;
    for (int k = 0; k < 8; k++) begin
      drive_cycle(k == 0, 0, k == 3, 32'h2000_0000, "cont_sample");
      n_checks++;
      if (obs_z !== zexp[k]) begin
        n_errors++;
        $display("FAIL cont_z[%0d]: got %h expected %h", k, obs_z, zexp[k]);
      end
    end
    drive_cycle(0, 1, 0, '0, "cont_stop");
    n_checks++;
    if (obs_en !== 1'b0 || obs_done !== 1'b1) begin
      n_errors++;
      $display("FAIL cont_stop: got en=%b done=%b expected en=0 done=1", obs_en, obs_done);
    end
    drive_cycle(0, 0, 0, '0, "cont_idle");
  endtask

  task automatic test_reset_mid_burst();
    logic [IW-1:0] off;
    len_in = 16'd10; amp_in = 16'h1234; phase_off_in = 16'($urandom);
    for (int k = 0; k < 3; k++) drive_cycle(k == 0, 0, 0, '0, "rmb_sample");
    #2 rst_n = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, en_out, mode_out, x_out, y_out, z_out} !== '0) begin
      n_errors++;
      $display("FAIL rmb_async: got %h expected 0", {busy, done, en_out, mode_out, x_out, y_out, z_out});
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || en_out !== 1'b0) begin
      n_errors++;
      $display("FAIL rmb_no_done: got done=%b en=%b expected 0 0", done, en_out);
    end
    rst_n = 1'b0;
    model_reset();
    drive_cycle(0, 0, 0, '0, "rmb_idle");
    drive_cycle(0, 0, 1, 32'($urandom), "rmb_load");
    off = 16'($urandom);
    len_in = 16'd2; phase_off_in = off;
    drive_cycle(1, 0, 0, '0, "rmb_restart");
    n_checks++;
    if (obs_z !== off || obs_en !== 1'b1) begin
      n_errors++;
      $display("FAIL rmb_first_z: got z=%h en=%b expected z=%h en=1", obs_z, obs_en, off);
    end
    for (int k = 0; k < 3; k++) drive_cycle(0, 0, 0, '0, "rmb_tail");
  endtask

  task automatic test_stop_start_idle();
    len_in = 16'd1; amp_in = 16'($urandom); phase_off_in = 16'($urandom);
    drive_cycle(1, 1, 0, '0, "ss_start");
    n_checks++;
    if (obs_en !== 1'b1) begin
      n_errors++;
      $display("FAIL ss_started: got en=%b expected 1", obs_en);
    end
    drive_cycle(0, 0, 0, '0, "ss_done");
    n_checks++;
    if (obs_done !== 1'b1) begin
      n_errors++;
      $display("FAIL ss_single: got done=%b expected 1", obs_done);
    end
    drive_cycle(1'b0, 1'b1, 0, '0, "ss_stop_idle");
  endtask

  task automatic test_back_to_back();
    len_in = 16'd2; amp_in = 16'h0101; phase_off_in = 16'h0F00;
    drive_cycle(1, 0, 0, '0, "b2b_s0");
    drive_cycle(0, 0, 0, '0, "b2b_s1");
    drive_cycle(1, 0, 0, '0, "b2b_done_start_ignored");
    drive_cycle(1, 0, 0, '0, "b2b_restart");
    n_checks++;
    if (obs_en !== 1'b1 || obs_z !== 16'h0F00) begin
      n_errors++;
      $display("FAIL b2b_restart_z: got en=%b z=%h expected en=1 z=0f00", obs_en, obs_z);
    end
    for (int k = 0; k < 3; k++) drive_cycle(0, 0, 0, '0, "b2b_tail");
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      drive_cycle(0, 0, 1, 32'($urandom), "rnd_load");
      len_in = LW'($urandom_range(0, 6));
      amp_in = 16'($urandom); phase_off_in = 16'($urandom);
      drive_cycle(1, 0, 0, '0, "rnd_start");
      for (int c = 0; c < 20 && m_run; c++) begin
        bit sp, st, fl;
        sp = (c == 14) || ($urandom_range(0, 9) == 0);
        st = m_run && !sp && (m_len == 0 || m_k < m_len) && ($urandom_range(0, 3) == 0);
        fl = ($urandom_range(0, 3) == 0);
        drive_cycle(st, sp, fl, 32'($urandom), "rnd_cycle");
      end
      drive_cycle(0, 0, 0, '0, "rnd_idle");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_quadrature();
    test_ignore_start();
    test_wrap();
    test_continuous();
    test_reset_mid_burst();
    test_stop_start_idle();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cordic_nco_drv.md
# cordic_nco_drv

Numerically controlled oscillator front end for `cordic_top`. It generates a registered stream of rotation-mode (mode 2) requests:
- `x` is a programmable amplitude, `y` is 0, and `z` is a phase ramp taken from a 32-bit phase accumulator plus a phase offset.

Its outputs connect directly to `cordic_top`'s `en_in`, `mode_in`, `x_in`, `y_in` and `z_in`, so that block produces a sine/cosine tone burst.

## Interface
- `IN_WIDTH`, 16, width of `x`/`y`/`z` words; matches `cordic_top` `IN_WIDTH`
- `PHASE_WIDTH`, 32, phase accumulator width; must be ≥ `IN_WIDTH`
- `LEN_WIDTH`, 16, burst length counter width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle burst start request
- `stop`  in  1  abort the running burst
- `len_in`  in  `LEN_WIDTH`  burst length in samples; 0 means continuous until `stop`
- `amp_in`  in  `IN_WIDTH`  amplitude, latched at start
- `phase_off_in`  in  `IN_WIDTH`  phase offset, latched at start; full scale = 360°
- `freq_in`  in  `PHASE_WIDTH`  phase increment per sample
- `freq_ld`  in  1  load `freq_in` into the active increment register
- `busy`  out  1  burst in progress
- `done`  out  1  single-cycle pulse at burst end
- `en_out`  out  1  to `cordic_top` `en_in`
- `mode_out`  out  2  to `mode_in`
- `x_out`  out  `IN_WIDTH`  to `x_in`
- `y_out`  out  `IN_WIDTH`  to `y_in`
- `z_out`  out  `IN_WIDTH`  to `z_in`

## Operation
- Two states: IDLE and RUN. All outputs are registered.
- Reset (`rst_n` = 1) forces:
  - state to IDLE
  - accumulator, active increment, sample counter and latched `amp`/`off`/`len` to 0
  - all outputs to 0
- Increment register `freq_act`:
  - `freq_ld` = 1 → `freq_act <= freq_in` on that edge.
  - Loading works in any state.
- IDLE → RUN when `start` = 1. On that edge:
  - `acc <= freq_act`, `cnt <= 1`
  - `amp`, `off` and `len` are latched
  - first sample is emitted with phase 0
- In RUN, every edge emits one sample:
  - `en_out <= 1`, `mode_out <= 2`, `x_out <= amp`, `y_out <= 0`
  - `z_out <= acc[PHASE_WIDTH-1 -: IN_WIDTH] + off`, modulo 2^`IN_WIDTH`
  - `acc <= acc + freq_act`, modulo 2^`PHASE_WIDTH`
  - `cnt <= cnt + 1`
- Sample k therefore has phase `top(Σ increments) + off`. Sample 0 has `z_out = off`.
- RUN → IDLE:
  - when `len` ≠ 0 and `len` samples have been emitted, or
  - when `stop` = 1.
- On the exit edge:
  - `en_out`, `mode_out`, `x_out`, `y_out`, `z_out` and `busy` go to 0
  - `done` pulses for exactly one cycle
  - no sample is emitted
- `busy` = 1 exactly while in RUN.
- Priority rules:
  - `start` while in RUN is ignored.
  - `stop` while in IDLE is ignored.
  - `stop` and `start` together in IDLE → start wins.
  - In RUN, `stop` wins over the length count.
- `len` = 1 gives a single sample.
- In continuous mode (`len` = 0) `cnt` saturates, and only `stop` ends the burst.
- `freq_ld` during RUN: the new increment applies from the next accumulation, so the phase stays continuous.

## Timing
- `start` sampled at edge E0 → first sample (`en_out` = 1, `z_out = off`) visible after E0.
- Sample k is visible after edge E0+k.
- Burst of length L: samples are on edges E0 … E0+L−1. At edge E0+L, `en_out` = 0 and `done` = 1; `done` = 0 again after E0+L+1.
- `stop` sampled at edge Es: `en_out`/`busy` = 0 and `done` = 1 after Es; no further samples.
- `freq_ld` sampled at edge Ef: `freq_act` is updated after Ef.
  - The sample emitted at Ef+1 still uses the increment accumulated at Ef, which was the old value.
  - Samples from Ef+2 onward reflect the new increment.
- Reset mid-burst: outputs are 0 immediately (asynchronous), with no `done` pulse. After reset is released, the block is in IDLE and requires a new `start`.
- Back-to-back bursts: `start` is accepted at the `done` edge + 1 at the earliest.

## Test plan
- `freq_ld` with `freq_in` = 0x4000_0000 (90°), then `start` with `len` = 8, `amp` = 0x7FFF, `off` = 0:
  - 8 consecutive samples with `z` = 0000, 4000, 8000, C000, 0000, 4000, 8000, C000
  - `x` = 7FFF, `y` = 0, `mode` = 2 throughout
  - `done` pulse one cycle after the 8th sample
- `freq` = 0, `off` = 0x2000, `len` = 3: three samples with `z` = 2000, then `done`; a `start` during the burst is ignored (no extension).
- `freq` = 0xFFFF_FFFF, `len` = 3: `z` = 0000, FFFF, FFFF, exercising accumulator wrap.
- `freq` = 0x1000_0000, `len` = 0, then `freq_ld` 0x2000_0000 at sample 3:
  - `z` steps of 1000 switch to steps of 2000 at sample 5 without a phase jump
  - `stop` at sample 8: `en_out` drops the next cycle and `done` pulses once
- Assert reset mid-burst (sample 2 of `len` = 10): all outputs are 0 at once with no `done`. After release, `start` with `len` = 2 produces 2 samples starting from `z = off`.
- `stop` and `start` together in IDLE: the burst starts. `len` = 1: exactly one sample, then `done`.
